// File: rtl/note_env_ctrl.sv
// Note-lifecycle sequencer: gates and clears the phase accumulator, runs a linear
// attack/release envelope, and scales each synth sample around PWM mid-scale.
module note_env_ctrl #(
    parameter int DATA_W = 12,
    parameter int ENV_W  = 12,
    parameter int STEP_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              synth_reset,
    input  logic              note_start,
    input  logic              note_release,
    input  logic              note_reset,
    input  logic [STEP_W-1:0] attack_step,
    input  logic [STEP_W-1:0] release_step,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic              accum_en,
    output logic              accum_clear,
    output logic [ENV_W-1:0]  env_level,
    output logic              note_active,
    output logic              note_finished,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_SUSTAIN = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int SUM_W  = ((ENV_W > STEP_W) ? ENV_W : STEP_W) + 1;
    localparam int PROD_W = DATA_W + ENV_W + 2;

    localparam logic [ENV_W-1:0]  ENV_MAX = {ENV_W{1'b1}};
    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] CODE_MAX = {DATA_W{1'b1}};
    localparam logic signed [PROD_W-1:0] MID_S = {{(PROD_W-DATA_W){1'b0}}, MID};
    localparam logic signed [PROD_W-1:0] CODE_MAX_S = {{(PROD_W-DATA_W){1'b0}}, CODE_MAX};

    state_t            state, state_next;
    logic [ENV_W-1:0]  env_next;
    logic              finished_next;
    logic              clear_next;
    logic              in_note;

    logic [SUM_W-1:0]  env_ext;
    logic [SUM_W-1:0]  atk_ext;
    logic [SUM_W-1:0]  rel_ext;
    logic [SUM_W-1:0]  atk_sum;
    logic [SUM_W-1:0]  rel_diff;

    // Valid/ready: there is no back-pressure. sample_in_valid marks a sample
    // accepted this cycle; sample_out_valid marks the scaled result exactly one
    // cycle later and must be consumed on that cycle.

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            env_level     <= '0;
            note_finished <= 1'b0;
            accum_clear   <= 1'b0;
        end else begin
            state         <= state_next;
            env_level     <= env_next;
            note_finished <= finished_next;
            accum_clear   <= clear_next;
        end
    end

    always_comb begin
        in_note  = (state == S_ATTACK) || (state == S_SUSTAIN) || (state == S_RELEASE);
        env_ext  = SUM_W'(env_level);
        atk_ext  = SUM_W'(attack_step);
        rel_ext  = SUM_W'(release_step);
        atk_sum  = env_ext + atk_ext;
        rel_diff = env_ext - rel_ext;
    end

    // Only the highest-priority strobe that actually acts is honoured; the
    // envelope advances only on accepted samples when no strobe acted.
    always_comb begin
        state_next    = state;
        env_next      = env_level;
        finished_next = note_finished;
        clear_next    = 1'b0;
        if (synth_reset || note_reset) begin
            state_next    = S_IDLE;
            env_next      = '0;
            finished_next = 1'b0;
            clear_next    = 1'b1;
        end else if (note_start) begin
            state_next    = S_ATTACK;
            finished_next = 1'b0;
            if (!in_note) begin
                env_next   = '0;
                clear_next = 1'b1;
            end
        end else if (note_release && ((state == S_ATTACK) || (state == S_SUSTAIN))) begin
            state_next = S_RELEASE;
        end else if (sample_in_valid) begin
            case (state)
                S_ATTACK: begin
                    if (atk_sum >= SUM_W'(ENV_MAX)) begin
                        env_next   = ENV_MAX;
                        state_next = S_SUSTAIN;
                    end else begin
                        env_next = atk_sum[ENV_W-1:0];
                    end
                end
                S_RELEASE: begin
                    if (env_ext <= rel_ext) begin
                        env_next      = '0;
                        state_next    = S_DONE;
                        finished_next = 1'b1;
                    end else begin
                        env_next = rel_diff[ENV_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        accum_en    = (state == S_ATTACK) || (state == S_SUSTAIN) || (state == S_RELEASE);
        note_active = accum_en;
        state_dbg   = state;
    end

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] env_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [PROD_W-1:0] scaled_sum;
    logic [DATA_W-1:0]        scaled;
    logic [DATA_W-1:0]        sample_next;

    // Scaling uses the envelope as it stands before this cycle's update; the
    // arithmetic shift floors negative offsets toward the bottom rail.
    always_comb begin
        diff       = $signed({1'b0, sample_in}) - $signed({1'b0, MID});
        diff_ext   = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
        env_s      = {{(PROD_W-ENV_W){1'b0}}, env_level};
        prod       = diff_ext * env_s;
        shifted    = prod >>> ENV_W;
        scaled_sum = MID_S + shifted;
        if (scaled_sum < 0) begin
            scaled = '0;
        end else if (scaled_sum > CODE_MAX_S) begin
            scaled = CODE_MAX;
        end else begin
            scaled = scaled_sum[DATA_W-1:0];
        end

        if (!in_note || (env_level == '0)) begin
            sample_next = MID;
        end else if (env_level == ENV_MAX) begin
            sample_next = sample_in;
        end else begin
            sample_next = scaled;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || synth_reset) begin
            sample_out       <= MID;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out       <= sample_next;
            sample_out_valid <= sample_in_valid;
        end
    end

endmodule

// File: tb/tb_note_env_ctrl.sv
// Bench for note_env_ctrl: table of one-cycle vectors with expected control outputs,
// plus a queue of expected scaled samples popped as sample_out_valid appears.
module tb_note_env_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_SUSTAIN = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        synth_reset, note_start, note_release, note_reset;
  logic [11:0] attack_step, release_step, sample_in;
  logic        sample_in_valid;
  logic [11:0] sample_out;
  logic        sample_out_valid, accum_en, accum_clear, note_active, note_finished;
  logic [11:0] env_level;
  logic [2:0]  state_dbg;

  note_env_ctrl #(.DATA_W(12), .ENV_W(12), .STEP_W(12)) dut (
    .clk(clk), .rst(rst), .synth_reset(synth_reset), .note_start(note_start),
    .note_release(note_release), .note_reset(note_reset),
    .attack_step(attack_step), .release_step(release_step),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .accum_en(accum_en), .accum_clear(accum_clear), .env_level(env_level),
    .note_active(note_active), .note_finished(note_finished), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sr, st, rl, nr;
    logic [11:0] as_step, rs_step, sin;
    logic        v;
    logic [11:0] e_env;
    logic [2:0]  e_state;
    logic        e_clear, e_fin;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          model_env = 0;
  logic [2:0]  model_state = ST_IDLE;

  function automatic vec_t mk(logic sr, logic st, logic rl, logic nr,
                              int as_s, int rs_s, int sin, logic v,
                              int e_env, logic [2:0] e_state, logic e_clear, logic e_fin);
    vec_t r;
    r.sr = sr; r.st = st; r.rl = rl; r.nr = nr;
    r.as_step = 12'(as_s); r.rs_step = 12'(rs_s); r.sin = 12'(sin); r.v = v;
    r.e_env = 12'(e_env); r.e_state = e_state; r.e_clear = e_clear; r.e_fin = e_fin;
    return r;
  endfunction

  // Reference scaling: mid + floor((sin-mid)*env/4096), with exact end points.
  function automatic logic [11:0] model_scale(logic [11:0] sin, int env, logic [2:0] st);
    int d, p, q, r;
    if (st == ST_IDLE || st == ST_DONE || env == 0) return 12'd2048;
    if (env == 4095) return sin;
    d = int'(sin) - 2048;
    p = d * env;
    q = (p >= 0) ? (p / 4096) : -((-p + 4095) / 4096);
    r = 2048 + q;
    if (r < 0) r = 0;
    if (r > 4095) r = 4095;
    return 12'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic sb_check();
    if (sample_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_out_spurious: got valid sample %0d expected no output", sample_out);
      end else begin
        check("sample_out", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic check_ctrl(input string tag, input int e_env, input logic [2:0] e_state,
                            input logic e_clear, input logic e_fin);
    logic active;
    active = (e_state == ST_ATTACK) || (e_state == ST_SUSTAIN) || (e_state == ST_RELEASE);
    check({tag, ".env"}, 32'(env_level), 32'(e_env));
    check({tag, ".state"}, 32'(state_dbg), 32'(e_state));
    check({tag, ".accum_clear"}, 32'(accum_clear), 32'(e_clear));
    check({tag, ".finished"}, 32'(note_finished), 32'(e_fin));
    check({tag, ".accum_en"}, 32'(accum_en), 32'(active));
    check({tag, ".note_active"}, 32'(note_active), 32'(active));
  endtask

  // driver: apply one vector for exactly one clock, then check
  task automatic drive(input vec_t v, input string tag);
    @(negedge clk);
    synth_reset = v.sr; note_start = v.st; note_release = v.rl; note_reset = v.nr;
    attack_step = v.as_step; release_step = v.rs_step;
    sample_in = v.sin; sample_in_valid = v.v;
    if (v.v && !v.sr) exp_q.push_back(model_scale(v.sin, model_env, model_state));
    @(posedge clk);
    #1;
    sb_check();
    check_ctrl(tag, int'(v.e_env), v.e_state, v.e_clear, v.e_fin);
    model_env   = int'(v.e_env);
    model_state = v.e_state;
  endtask

  initial begin
    rst = 1'b1;
    synth_reset = 0; note_start = 0; note_release = 0; note_reset = 0;
    attack_step = 0; release_step = 0; sample_in = 12'd2048; sample_in_valid = 0;
    @(posedge clk);
    #1;
    check_ctrl("reset", 0, ST_IDLE, 1'b0, 1'b0);
    check("reset.sample_out", 32'(sample_out), 32'd2048);
    check("reset.sample_out_valid", 32'(sample_out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //                sr st rl nr  atk   rel   sin  v    env  state       clr fin
    vecs.push_back(mk(0, 0, 1, 0,    0,    0, 2048, 0,     0, ST_IDLE,    0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1024, 1000, 2048, 0,     0, ST_ATTACK,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  1024, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  2048, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  3072, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  4095, ST_SUSTAIN, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  4095, ST_SUSTAIN, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 1000, 1,  4095, ST_SUSTAIN, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1024, 1000,  500, 1,  4095, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3048, 1,  3095, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 1000, 1,  2095, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 2048, 1,  1095, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 4095, 1,    95, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000,    0, 1,     0, ST_DONE,    0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1024, 1000, 3000, 1,     0, ST_DONE,    0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1024, 1000, 3000, 0,     0, ST_DONE,    0, 1));
    vecs.push_back(mk(0, 1, 1, 0,    1, 1000, 3048, 1,     0, ST_ATTACK,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  500,  100, 3048, 1,   500, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  500,  100, 3048, 1,  1000, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  500,  100, 3048, 1,  1500, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  500,  100, 3048, 0,  1500, ST_RELEASE, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  500,  100, 3048, 1,  1500, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  100, 3048, 1,  1500, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 1,    0,  100, 3048, 1,     0, ST_IDLE,    1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4000,  100, 3048, 0,     0, ST_ATTACK,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4000,  100, 1500, 1,  4000, ST_ATTACK,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4000,  100, 1500, 1,  4095, ST_SUSTAIN, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4000,  100, 3048, 1,     0, ST_IDLE,    1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4000,  100, 3048, 1,     0, ST_IDLE,    0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("vec%0d", i));
    end

    // retrigger from SUSTAIN keeps full level and does not clear the accumulator
    drive(mk(0, 1, 0, 0, 4095, 100, 1000, 0,    0, ST_ATTACK,  1, 0), "retrig.start");
    drive(mk(0, 0, 0, 0, 4095, 100, 1000, 1, 4095, ST_SUSTAIN, 0, 0), "retrig.tick");
    drive(mk(0, 1, 0, 0,    0, 100, 1000, 1, 4095, ST_ATTACK,  0, 0), "retrig.again");
    drive(mk(0, 0, 0, 0,    0, 100,  700, 1, 4095, ST_SUSTAIN, 0, 0), "retrig.zero_step");

    // rst mid-note: everything back to idle and no accumulator clear pulse
    drive(mk(0, 0, 1, 0, 0, 2000, 3048, 1, 4095, ST_RELEASE, 0, 0), "rstseq.rel");
    drive(mk(0, 0, 0, 0, 0, 2000, 3048, 1, 2095, ST_RELEASE, 0, 0), "rstseq.tick");
    @(negedge clk);
    rst = 1'b1;
    note_start = 1'b1; sample_in_valid = 1'b1; sample_in = 12'd3048;
    @(posedge clk);
    #1;
    check_ctrl("rstseq.rst", 0, ST_IDLE, 1'b0, 1'b0);
    check("rstseq.sample_out", 32'(sample_out), 32'd2048);
    check("rstseq.sample_out_valid", 32'(sample_out_valid), 32'd0);
    model_env = 0;
    model_state = ST_IDLE;
    @(negedge clk);
    rst = 1'b0;
    note_start = 1'b0;
    sample_in_valid = 1'b0;
    @(posedge clk);
    #1;
    sb_check();
    check_ctrl("rstseq.after", 0, ST_IDLE, 1'b0, 1'b0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
